// File: rtl/mips32_prog_loader.sv
// Framed byte-stream program loader for pipe_MIPS32: writes image words, then releases the CPU.
// Define MIPS_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module mips32_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = 1024
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              cpu_halted,
    output logic              cpu_halt,
    output logic              cpu_start,
    output logic [ADDR_W-1:0] start_pc,
    output logic              load_done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_FLUSH,
        S_CHK,
        S_START,
        S_RUN
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  bcnt;
    logic [15:0] cnt, base, widx;
    logic [23:0] wbuf;
    logic        halted_q;

    logic        xfer, hdr_last, word_done, frame_last;
    logic        halt_rise, addr_bad, base_bad;
    logic [15:0] base_nx;
    logic [16:0] waddr;

    assign in_ready   = ~rst & (state == S_HDR || state == S_DATA
                                || state == S_CHK);
    assign xfer       = in_valid & in_ready;
    assign hdr_last   = xfer && state == S_HDR && bcnt == 2'd3;
    assign word_done  = xfer && state == S_DATA && bcnt == 2'd3;
    assign frame_last = word_done && widx == cnt - 16'd1;
    assign halt_rise  = cpu_halted & ~halted_q;
    assign base_nx    = {base[15:8], in_data};
    // 17-bit sums so BASE+idx never wraps back into range
    assign waddr      = {1'b0, base} + {1'b0, widx};
    assign addr_bad   = waddr >= 17'(MEM_DEPTH);
    assign base_bad   = {1'b0, base_nx} >= 17'(MEM_DEPTH);
    assign start_pc   = base[ADDR_W-1:0];

`ifdef MIPS_LOADER_CHECKSUM_EN
    logic [7:0] xsum;
    logic       chk_ok;

    assign chk_ok = (in_data == xsum) && !err;

    always_ff @(posedge clk1) begin
        if (rst)
            xsum <= 8'd0;
        else if (xfer)
            xsum <= (state == S_HDR && bcnt == 2'd0) ? in_data
                                                     : xsum ^ in_data;
    end
`endif

    always_ff @(posedge clk1) begin
        if (rst)
            state <= S_HDR;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cpu_start = 1'b0;
        unique case (state)
            S_HDR: begin
                if (hdr_last) begin
                    if (cnt != 16'd0)
                        state_nx = S_DATA;
`ifdef MIPS_LOADER_CHECKSUM_EN
                    else
                        state_nx = S_CHK;
`else
                    else if (base_bad)
                        state_nx = S_HDR;
                    else
                        state_nx = S_START;
`endif
                end
            end
            S_DATA: begin
`ifdef MIPS_LOADER_CHECKSUM_EN
                if (frame_last)
                    state_nx = S_CHK;
`else
                if (frame_last)
                    state_nx = S_FLUSH;
`endif
            end
            // lets the final write retire before cpu_start
            S_FLUSH: state_nx = err ? S_HDR : S_START;
            S_CHK: begin
`ifdef MIPS_LOADER_CHECKSUM_EN
                if (xfer)
                    state_nx = chk_ok ? S_START : S_HDR;
`else
                state_nx = S_HDR;
`endif
            end
            S_START: begin
                cpu_start = 1'b1;
                state_nx  = S_RUN;
            end
            S_RUN: begin
                if (halt_rise)
                    state_nx = S_HDR;
            end
            default: state_nx = S_HDR;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            bcnt      <= 2'd0;
            cnt       <= 16'd0;
            base      <= 16'd0;
            widx      <= 16'd0;
            wbuf      <= 24'd0;
            halted_q  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            cpu_halt  <= 1'b1;
            load_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            halted_q <= cpu_halted;
            if (xfer && state != S_CHK)
                bcnt <= bcnt + 2'd1;
            if (xfer && state == S_HDR) begin
                widx <= 16'd0;
                unique case (bcnt)
                    2'd0: begin
                        cnt[15:8] <= in_data;
                        load_done <= 1'b0;
                        err       <= 1'b0;
                    end
                    2'd1: cnt[7:0]   <= in_data;
                    2'd2: base[15:8] <= in_data;
                    default: begin
                        base[7:0] <= in_data;
                        if (cnt == 16'd0 && base_bad)
                            err <= 1'b1;
                    end
                endcase
            end
            if (xfer && state == S_DATA) begin
                wbuf <= {wbuf[15:0], in_data};
                if (word_done) begin
                    mem_we    <= ~addr_bad;
                    mem_addr  <= waddr[ADDR_W-1:0];
                    mem_wdata <= {wbuf, in_data};
                    widx      <= widx + 16'd1;
                    if (addr_bad)
                        err <= 1'b1;
                end
            end
            if (state_nx == S_START && state != S_START) begin
                cpu_halt  <= 1'b0;
                load_done <= 1'b1;
            end
            if (state == S_RUN && halt_rise)
                cpu_halt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: frame table plus random frames checked against a write-list model.
// Appends the XOR byte when MIPS_LOADER_CHECKSUM_EN is defined.
module tb_mips32_prog_loader;
    localparam int ADDR_W    = 10;
    localparam int MEM_DEPTH = 1024;

    logic              clk1 = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              cpu_halted = 1'b0;
    logic              in_ready, mem_we, cpu_halt, cpu_start;
    logic              load_done, err;
    logic [ADDR_W-1:0] mem_addr, start_pc;
    logic [31:0]       mem_wdata;

    always #5 clk1 = ~clk1;

    mips32_prog_loader #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_halted(cpu_halted),
        .cpu_halt  (cpu_halt),
        .cpu_start (cpu_start),
        .start_pc  (start_pc),
        .load_done (load_done),
        .err       (err)
    );

    typedef struct { int a; logic [31:0] d; int cyc; } wr_t;
    typedef struct { int pc; logic ld; logic halt; logic we; int cyc; } st_t;
    typedef struct {
        int cnt; int base; int gap; int sel; bit bad_chk; bit exp_err;
    } vec_t;

    wr_t         wq[$];
    st_t         sq[$];
    logic [31:0] img[$];
    int          cyc = 0;
    int          npass = 0;
    int          ntot = 0;

    always @(posedge clk1) cyc <= cyc + 1;

    always @(negedge clk1) begin
        if (mem_we === 1'b1)
            wq.push_back('{int'(mem_addr), mem_wdata, cyc});
        if (cpu_start === 1'b1)
            sq.push_back('{int'(start_pc), load_done, cpu_halt, mem_we, cyc});
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        ntot++;
        if (got === exp)
            npass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic check_reset(input string t);
        check({t, "_in_ready"}, 64'(in_ready), 0);
        check({t, "_mem_we"}, 64'(mem_we), 0);
        check({t, "_mem_addr"}, 64'(mem_addr), 0);
        check({t, "_mem_wdata"}, 64'(mem_wdata), 0);
        check({t, "_cpu_halt"}, 64'(cpu_halt), 1);
        check({t, "_cpu_start"}, 64'(cpu_start), 0);
        check({t, "_start_pc"}, 64'(start_pc), 0);
        check({t, "_load_done"}, 64'(load_done), 0);
        check({t, "_err"}, 64'(err), 0);
    endtask

    // gap 0: back-to-back, 1: one idle cycle per byte, 2: random idles
    task automatic put_byte(input logic [7:0] b, input int gap);
        int idle;
        int waitc;
        idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (idle) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk1); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        waitc    = 0;
        while (!in_ready && waitc < 100) begin
            @(posedge clk1); #1;
            waitc++;
        end
        if (!in_ready) begin
            check("ready_timeout", 64'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk1); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_bytes(input int cnt, input int base, input int gap,
                              input bit bad_chk);
        logic [7:0]  bs[$];
        logic [15:0] c16, b16;
        c16 = 16'(cnt);
        b16 = 16'(base);
        bs  = {c16[15:8], c16[7:0], b16[15:8], b16[7:0]};
        for (int i = 0; i < cnt; i++) begin
            bs.push_back(img[i][31:24]);
            bs.push_back(img[i][23:16]);
            bs.push_back(img[i][15:8]);
            bs.push_back(img[i][7:0]);
        end
`ifdef MIPS_LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'd0;
            foreach (bs[k]) x = x ^ bs[k];
            bs.push_back(bad_chk ? ~x : x);
        end
`else
        if (bad_chk)
            $display("note: checksum flip ignored without checksum build");
`endif
        foreach (bs[k]) put_byte(bs[k], gap);
    endtask

    task automatic run_frame(input string t, input int cnt, input int base,
                             input int gap, input bit bad_chk, input bit eerr);
        wr_t ew[$];
        for (int i = 0; i < cnt; i++)
            if (base + i < MEM_DEPTH)
                ew.push_back('{base + i, img[i], 0});
        wq.delete();
        sq.delete();
        send_bytes(cnt, base, gap, bad_chk);
        repeat (6) @(posedge clk1);
        @(negedge clk1);
        check($sformatf("%s_nwr", t), 64'(wq.size()), 64'(ew.size()));
        for (int i = 0; i < ew.size() && i < wq.size(); i++)
            check($sformatf("%s_wr%0d", t, i), {wq[i].a, wq[i].d},
                  {ew[i].a, ew[i].d});
        check({t, "_err"}, 64'(err), 64'(eerr));
        check({t, "_nstart"}, 64'(sq.size()), eerr ? 0 : 1);
        check({t, "_load_done"}, 64'(load_done), 64'(!eerr));
        if (sq.size() > 0) begin
            check({t, "_start_pc"}, 64'(sq[0].pc), 64'(base % (1 << ADDR_W)));
            check({t, "_start_ld"}, 64'(sq[0].ld), 1);
            check({t, "_start_halt"}, 64'(sq[0].halt), 0);
            check({t, "_start_we"}, 64'(sq[0].we), 0);
            if (wq.size() > 0)
                check({t, "_wr_before_start"},
                      64'(wq[wq.size()-1].cyc < sq[0].cyc), 1);
        end
        if (!eerr) begin
            check({t, "_run_halt"}, 64'(cpu_halt), 0);
            check({t, "_run_ready"}, 64'(in_ready), 0);
            @(posedge clk1); #1;
            cpu_halted = 1'b1;
            @(negedge clk1);
            @(negedge clk1);
            check({t, "_halt_back"}, 64'(cpu_halt), 1);
            check({t, "_hdr_ready"}, 64'(in_ready), 1);
            @(posedge clk1); #1;
            cpu_halted = 1'b0;
        end else begin
            check({t, "_err_ready"}, 64'(in_ready), 1);
            check({t, "_err_halt"}, 64'(cpu_halt), 1);
            @(posedge clk1); #1;
        end
    endtask

    task automatic load_img(input int sel, input int cnt);
        img.delete();
        if (sel == 0)
            img = {32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                   32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
        else if (sel == 1)
            img = {32'h00000055};
        else
            for (int i = 0; i < cnt; i++) img.push_back($urandom);
    endtask

    initial begin
        vec_t vt[$];
        int   c, b;

        vt.push_back('{8, 0, 0, 0, 1'b0, 1'b0});
        vt.push_back('{8, 0, 1, 0, 1'b0, 1'b0});
        vt.push_back('{1, 120, 0, 1, 1'b0, 1'b0});
        vt.push_back('{3, 1022, 0, 2, 1'b0, 1'b1});
        vt.push_back('{0, 5, 0, 2, 1'b0, 1'b0});
        vt.push_back('{0, 2000, 2, 2, 1'b0, 1'b1});
        vt.push_back('{2, 1023, 2, 2, 1'b0, 1'b1});
        vt.push_back('{4, 1020, 2, 2, 1'b0, 1'b0});
`ifdef MIPS_LOADER_CHECKSUM_EN
        vt.push_back('{2, 40, 0, 2, 1'b1, 1'b1});
        vt.push_back('{0, 9, 1, 2, 1'b1, 1'b1});
        vt.push_back('{1, 41, 0, 2, 1'b0, 1'b0});
`endif

        repeat (3) @(posedge clk1);
        @(negedge clk1);
        check_reset("rst_init");
        rst = 1'b0;
        @(posedge clk1); #1;

        foreach (vt[k]) begin
            load_img(vt[k].sel, vt[k].cnt);
            run_frame($sformatf("vec%0d", k), vt[k].cnt, vt[k].base,
                      vt[k].gap, vt[k].bad_chk, vt[k].exp_err);
        end

        for (int r = 0; r < 8; r++) begin
            c = int'($urandom_range(1, 5));
            b = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1019))
                                            : int'($urandom_range(1018, 1030));
            load_img(2, c);
            run_frame($sformatf("rnd%0d", r), c, b, 2, 1'b0,
                      (b + c > MEM_DEPTH));
        end

        // reset in the middle of a data word
        load_img(2, 0);
        img = {32'hdeadbeef, 32'h01234567};
        wq.delete();
        foreach (img[i]) begin end
        put_byte(8'h00, 0);
        put_byte(8'h04, 0);
        put_byte(8'h00, 0);
        put_byte(8'h0a, 0);
        put_byte(8'hde, 0);
        put_byte(8'had, 0);
        put_byte(8'hbe, 0);
        put_byte(8'hef, 0);
        put_byte(8'h01, 0);
        @(negedge clk1);
        check("mid_nwr", 64'(wq.size()), 1);
        if (wq.size() > 0)
            check("mid_wr", {wq[0].a, wq[0].d}, {32'd10, 32'hdeadbeef});
        @(posedge clk1); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        check_reset("rst_mid");
        rst = 1'b0;
        @(posedge clk1); #1;
        load_img(2, 1);
        run_frame("fresh", 1, 7, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
